param_updown_counter: RTL

//  Parametrised up/down counter; successor of the 8-bit up counter. Adds width/modulus

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_prescaler.sv | 28 ++
 rtl/param_updown_counter.sv | 94 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the counter family: count direction and bound behaviour.
package counter_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// Modulo-DIV enable prescaler: emits a one-cycle step strobe on every DIV-th enabled cycle.
// Only instantiated when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic step
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] phase_q;

   assign step = en && (phase_q == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         phase_q <= '0;
      end else if (en) begin
         phase_q <= step ? '0 : phase_q + PW'(1);
      end
   end

endmodule : counter_prescaler

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate bounds and registered terminal-count pulse.
// Optional enable prescaler selected by defining COUNTER_PRESCALE_EN.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned MAX_VAL      = (1 << WIDTH) - 1,
   parameter int unsigned RESET_VAL    = 0,
   parameter int unsigned PRESCALE_DIV = 4
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic             LOAD,
   input  logic             UP,
   input  logic             MODE,
   input  logic [WIDTH-1:0] DATA,
   output logic [WIDTH-1:0] COUNT,
   output logic             TC
);

   // Elaboration-time sanity checks on the configuration.
   if (WIDTH < 2) begin : g_bad_width
      $error("param_updown_counter: WIDTH must be >= 2");
   end
   if (RESET_VAL > MAX_VAL) begin : g_bad_reset
      $error("param_updown_counter: RESET_VAL must be <= MAX_VAL");
   end
   if (PRESCALE_DIV < 1) begin : g_bad_div
      $error("param_updown_counter: PRESCALE_DIV must be >= 1");
   end

   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

   logic             step;
   logic [WIDTH:0]   cur_ext;
   logic [WIDTH:0]   data_ext;
   logic [WIDTH:0]   nxt_ext;
   logic             at_bound;
   logic [WIDTH-1:0] count_d;
   logic             tc_d;

`ifdef COUNTER_PRESCALE_EN
   counter_prescaler #(
      .DIV (PRESCALE_DIV)
   ) u_prescaler (
      .clk   (CLOCK),
      .rst_n (RESET),
      .clr   (LOAD),
      .en    (ENABLE),
      .step  (step)
   );
`else
   assign step = ENABLE;
`endif

   // Extended width keeps the MAX_VAL bound exact even when it is below 2**WIDTH-1.
   always_comb begin
      cur_ext  = {1'b0, COUNT};
      data_ext = {1'b0, DATA};
      nxt_ext  = cur_ext;
      tc_d     = 1'b0;
      at_bound = (UP == DIR_UP) ? (cur_ext == MAX_EXT) : (cur_ext == '0);

      if (LOAD) begin
         nxt_ext = (data_ext > MAX_EXT) ? MAX_EXT : data_ext;
      end else if (step) begin
         tc_d = at_bound;
         if (at_bound) begin
            if (MODE == MODE_WRAP) begin
               nxt_ext = (UP == DIR_UP) ? '0 : MAX_EXT;
            end
         end else if (UP == DIR_UP) begin
            nxt_ext = cur_ext + (WIDTH + 1)'(1);
         end else begin
            nxt_ext = cur_ext - (WIDTH + 1)'(1);
         end
      end

      count_d = nxt_ext[WIDTH-1:0];
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         COUNT <= RST_CNT;
         TC    <= 1'b0;
      end else begin
         COUNT <= count_d;
         TC    <= tc_d;
      end
   end

endmodule : param_updown_counter
